// File: rtl/mcpu_soc_intc.sv
// mcpu_soc_intc: interrupt controller for the MCPU SoC.
// Latches up to NSRC peripheral interrupt sources into a pending register,
// applies a software mask, and priority-selects one source (lowest index
// wins). That source is presented to the core on int_pending/int_type and
// held until the core acknowledges it with int_clear.
// Software reaches the block through a word-addressed MMIO port:
//   addr 0 PENDING (read pending, write-1-to-clear)
//   addr 1 MASK    (read/write, 1 = source enabled)
//   addr 2 RAW     (read registered irq_src, writes ignored)
//   addr 3 FORCE   (write-1-to-set pending, reads 0)
//
// Core handshake (int_pending / int_clear):
//   int_pending high means int_type names a valid pending source. int_type
//   stays stable for as long as int_pending is high. The core acknowledges
//   with a single-cycle int_clear pulse while int_pending is high. That pulse
//   clears the pending bit at int_type and drops int_pending on the same
//   edge. An int_clear while int_pending is low has no effect. int_pending
//   can also fall without an int_clear when software clears the presented
//   bit through PENDING. The core must treat that as a withdrawn request.
module mcpu_soc_intc #(
  parameter int          NSRC      = 16,
  parameter logic [15:0] EDGE_MASK = 16'hFFFF
) (
  input  logic            clkrst_core_clk,
  input  logic            clkrst_core_rst,
  input  logic [NSRC-1:0] irq_src,
  input  logic [1:0]      addr,
  input  logic [31:0]     data_in,
  input  logic [3:0]      wren,
  input  logic            re,
  output logic [31:0]     data_out,
  output logic            int_pending,
  output logic [3:0]      int_type,
  input  logic            int_clear
);

  // Register map word addresses
  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd1;
  localparam logic [1:0] ADDR_RAW     = 2'd2;
  localparam logic [1:0] ADDR_FORCE   = 2'd3;

  // Bits that correspond to real sources; everything above NSRC is held at 0
  localparam logic [15:0] SRC_BITS =
    (NSRC >= 16) ? 16'hFFFF : 16'((32'h1 << NSRC) - 32'h1);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  // FSM state, kept as a plainly named signal so checkers can bind to it
  state_t state;

  // Architectural registers, always 16 bits wide with unused bits at 0
  logic [15:0] pending;
  logic [15:0] mask;
  logic [15:0] src_q;

  // Combinational helpers
  logic [15:0] src_ext;
  logic [15:0] events;
  logic [15:0] lane_mask;
  logic [15:0] wbits;
  logic        wr_any;
  logic [15:0] force_bits;
  logic [15:0] w1c_bits;
  logic [15:0] ack_bits;
  logic [15:0] set_bits;
  logic [15:0] clr_bits;
  logic [15:0] pending_next;
  logic [15:0] mask_next;
  logic        mask_we;
  logic [15:0] active;
  logic        any_active;
  logic [3:0]  winner;
  logic        withdraw;
  logic [15:0] rd_mux;

  // Upper data lanes and byte enables carry nothing for 16-bit registers
  logic unused_bits;
  assign unused_bits = ^{data_in[31:16], wren[3:2]};

  // Widen the source lines to the 16-bit register width
  always_comb begin
    src_ext             = '0;
    src_ext[NSRC-1:0]   = irq_src;
  end

  // Per-source event: rising edge or level, selected per bit by EDGE_MASK
  assign events = ((src_ext & ~src_q & EDGE_MASK) |
                   (src_ext & ~EDGE_MASK)) & SRC_BITS;

  // MMIO write decode; only byte lanes 0 and 1 exist
  assign lane_mask  = {{8{wren[1]}}, {8{wren[0]}}};
  assign wbits      = data_in[15:0] & lane_mask & SRC_BITS;
  assign wr_any     = |wren[1:0];
  assign force_bits = (addr == ADDR_FORCE)   ? wbits : 16'h0;
  assign w1c_bits   = (addr == ADDR_PENDING) ? wbits : 16'h0;
  assign mask_we    = (addr == ADDR_MASK) && wr_any;
  assign mask_next  = ((mask & ~lane_mask) | (data_in[15:0] & lane_mask)) &
                      SRC_BITS;

  // Core acknowledge only counts while a source is being presented
  assign ack_bits = (state == ST_PRESENT && int_clear) ?
                    (16'h1 << int_type) : 16'h0;

  // Set takes priority over clear on the same bit in the same cycle
  assign set_bits     = events | force_bits;
  assign clr_bits     = w1c_bits | ack_bits;
  assign pending_next = ((pending & ~clr_bits) | set_bits) & SRC_BITS;

  // Arbitration runs on the registered pending/mask values
  assign active     = pending & mask;
  assign any_active = |active;

  // Lowest set index wins; scan downward so the last hit is the lowest
  always_comb begin
    winner = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (active[i]) winner = 4'(i);
    end
  end

  // Software clearing the presented bit withdraws it, unless it re-fires now
  assign withdraw = w1c_bits[int_type] & ~set_bits[int_type];

  // Read data source for the addressed register
  always_comb begin
    rd_mux = 16'h0;
    case (addr)
      ADDR_PENDING: rd_mux = pending;
      ADDR_MASK:    rd_mux = mask;
      ADDR_RAW:     rd_mux = src_q;
      ADDR_FORCE:   rd_mux = 16'h0;
      default:      rd_mux = 16'h0;
    endcase
  end

  // Register the raw source lines every cycle (edge detect and RAW readback)
  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) src_q <= 16'h0;
    else                 src_q <= src_ext & SRC_BITS;
  end

  // Pending register update: events and FORCE set, W1C and ack clear
  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) pending <= 16'h0;
    else                 pending <= pending_next;
  end

  // Mask register, written per byte lane
  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst)  mask <= 16'h0;
    else if (mask_we)     mask <= mask_next;
  end

  // Read data is captured on re and held until the next read
  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) data_out <= 32'h0;
    else if (re)         data_out <= {16'h0, rd_mux};
  end

  // Presentation FSM: pick a source in IDLE, hold it in PRESENT until ack
  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      state       <= ST_IDLE;
      int_pending <= 1'b0;
      int_type    <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_active) begin
            int_type    <= winner;
            int_pending <= 1'b1;
            state       <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (int_clear) begin
            int_pending <= 1'b0;
            state       <= ST_IDLE;
          end else if (withdraw) begin
            int_pending <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          int_pending <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcpu_soc_intc.sv
// tb_mcpu_soc_intc: self-checking bench for the MCPU SoC interrupt controller.
// MMIO read results go through an expected-value queue; presentation outputs
// are checked directly against values worked out from the intended behaviour.
module tb_mcpu_soc_intc;

  localparam int          NSRC      = 16;
  localparam logic [15:0] EDGE_MASK = 16'hFFDF;  // source 5 is level mode

  logic        clk;
  logic        rst;
  logic [15:0] irq_src;
  logic [1:0]  addr;
  logic [31:0] data_in;
  logic [3:0]  wren;
  logic        re;
  logic [31:0] data_out;
  logic        int_pending;
  logic [3:0]  int_type;
  logic        int_clear;

  int n_vec;
  int n_err;
  logic [31:0] exp_q[$];

  mcpu_soc_intc #(
    .NSRC      (NSRC),
    .EDGE_MASK (EDGE_MASK)
  ) dut (
    .clkrst_core_clk (clk),
    .clkrst_core_rst (rst),
    .irq_src         (irq_src),
    .addr            (addr),
    .data_in         (data_in),
    .wren            (wren),
    .re              (re),
    .data_out        (data_out),
    .int_pending     (int_pending),
    .int_type        (int_type),
    .int_clear       (int_clear)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "bench timeout");
  end

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock and settle just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mmio_write(input logic [1:0] a, input logic [31:0] d,
                            input logic [3:0] be);
    addr    = a;
    data_in = d;
    wren    = be;
    step();
    wren    = 4'h0;
    data_in = 32'h0;
  endtask

  // Issue a read, queue its expected data, then compare when data_out is valid
  task automatic mmio_read(input string tag, input logic [1:0] a,
                           input logic [15:0] exp);
    logic [31:0] want;
    addr = a;
    re   = 1'b1;
    exp_q.push_back({16'h0, exp});
    step();
    re   = 1'b0;
    if (exp_q.size() == 0) begin
      check_val({tag, "_qempty"}, 32'h1, 32'h0);
    end else begin
      want = exp_q.pop_front();
      check_val(tag, data_out, want);
    end
  endtask

  task automatic ack();
    int_clear = 1'b1;
    step();
    int_clear = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hits;
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    irq_src   = 16'h0;
    addr      = 2'd0;
    data_in   = 32'h0;
    wren      = 4'h0;
    re        = 1'b0;
    int_clear = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check_val("rst_int_pending", {31'h0, int_pending}, 32'h0);
    check_val("rst_int_type", {28'h0, int_type}, 32'h0);
    check_val("rst_data_out", data_out, 32'h0);
    mmio_read("rst_pending", 2'd0, 16'h0);
    mmio_read("rst_mask", 2'd1, 16'h0);

    // Single edge source through to ack
    mmio_write(2'd1, 32'h0010, 4'hF);
    irq_src = 16'h0010;
    step();
    irq_src = 16'h0;
    check_val("t1_not_yet", {31'h0, int_pending}, 32'h0);
    mmio_read("t1_pending", 2'd0, 16'h0010);
    check_val("t1_present", {31'h0, int_pending}, 32'h1);
    check_val("t1_type", {28'h0, int_type}, 32'd4);
    ack();
    check_val("t1_acked", {31'h0, int_pending}, 32'h0);
    mmio_read("t1_pending_clr", 2'd0, 16'h0);
    check_val("t1_idle", {31'h0, int_pending}, 32'h0);

    // Priority and no re-arbitration while presenting
    mmio_write(2'd1, 32'hFFFF, 4'hF);
    irq_src = 16'h0208;
    step();
    irq_src = 16'h0;
    step();
    check_val("t2_present", {31'h0, int_pending}, 32'h1);
    check_val("t2_type3", {28'h0, int_type}, 32'd3);
    irq_src = 16'h0002;
    step();
    irq_src = 16'h0;
    step();
    check_val("t2_frozen", {28'h0, int_type}, 32'd3);
    ack();
    check_val("t2_ack3", {31'h0, int_pending}, 32'h0);
    step();
    check_val("t2_pres1", {31'h0, int_pending}, 32'h1);
    check_val("t2_type1", {28'h0, int_type}, 32'd1);
    ack();
    step();
    check_val("t2_pres9", {31'h0, int_pending}, 32'h1);
    check_val("t2_type9", {28'h0, int_type}, 32'd9);
    mmio_read("t2_pending9", 2'd0, 16'h0200);
    ack();
    check_val("t2_ack9", {31'h0, int_pending}, 32'h0);
    step();
    check_val("t2_empty", {31'h0, int_pending}, 32'h0);

    // Edge source held high: one presentation only
    irq_src = 16'h0004;
    step();
    step();
    check_val("t3_present", {31'h0, int_pending}, 32'h1);
    check_val("t3_type2", {28'h0, int_type}, 32'd2);
    ack();
    hits = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (int_pending) hits++;
    end
    check_val("t3_no_repeat", hits, 32'd0);
    irq_src = 16'h0;
    step();

    // Level source re-presents after ack, then W1C retires it
    irq_src = 16'h0020;
    step();
    step();
    check_val("t4_present", {31'h0, int_pending}, 32'h1);
    check_val("t4_type5", {28'h0, int_type}, 32'd5);
    ack();
    check_val("t4_acked", {31'h0, int_pending}, 32'h0);
    step();
    check_val("t4_repres", {31'h0, int_pending}, 32'h1);
    check_val("t4_retype5", {28'h0, int_type}, 32'd5);
    irq_src = 16'h0;
    step();
    mmio_write(2'd0, 32'h0020, 4'hF);
    check_val("t4_withdrawn", {31'h0, int_pending}, 32'h0);
    step();
    step();
    step();
    check_val("t4_stays_low", {31'h0, int_pending}, 32'h0);
    mmio_read("t4_pending", 2'd0, 16'h0);

    // FORCE with mask off, then unmask, then withdraw by W1C
    mmio_write(2'd1, 32'h0000, 4'hF);
    mmio_write(2'd3, 32'h8000, 4'hF);
    mmio_read("t5_pending", 2'd0, 16'h8000);
    check_val("t5_masked", {31'h0, int_pending}, 32'h0);
    mmio_read("t5_force_rd", 2'd3, 16'h0);
    mmio_write(2'd1, 32'h8000, 4'hF);
    step();
    check_val("t5_present", {31'h0, int_pending}, 32'h1);
    check_val("t5_type15", {28'h0, int_type}, 32'd15);
    mmio_write(2'd0, 32'h8000, 4'hF);
    check_val("t5_withdrawn", {31'h0, int_pending}, 32'h0);
    mmio_read("t5_pending_clr", 2'd0, 16'h0);

    // Ack and new edge on the same source in the same cycle
    mmio_write(2'd1, 32'hFFFF, 4'hF);
    irq_src = 16'h0080;
    step();
    irq_src = 16'h0;
    step();
    check_val("t6_present", {31'h0, int_pending}, 32'h1);
    check_val("t6_type7", {28'h0, int_type}, 32'd7);
    irq_src   = 16'h0080;
    int_clear = 1'b1;
    step();
    int_clear = 1'b0;
    irq_src   = 16'h0;
    check_val("t6_acked", {31'h0, int_pending}, 32'h0);
    step();
    check_val("t6_repres", {31'h0, int_pending}, 32'h1);
    check_val("t6_retype7", {28'h0, int_type}, 32'd7);
    mmio_read("t6_pending", 2'd0, 16'h0080);

    // Reset while presenting
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("t6_rst_pend", {31'h0, int_pending}, 32'h0);
    check_val("t6_rst_type", {28'h0, int_type}, 32'h0);
    check_val("t6_rst_dout", data_out, 32'h0);
    mmio_read("t6_rst_pending", 2'd0, 16'h0);
    mmio_read("t6_rst_mask", 2'd1, 16'h0);

    // Byte lanes and RAW readback
    mmio_write(2'd1, 32'hFFFF_FFFF, 4'b0001);
    mmio_read("bl_lane0", 2'd1, 16'h00FF);
    mmio_write(2'd1, 32'hFFFF_FFFF, 4'b1100);
    mmio_read("bl_upper_ignored", 2'd1, 16'h00FF);
    mmio_write(2'd1, 32'h0000_A500, 4'b0010);
    mmio_read("bl_lane1", 2'd1, 16'hA5FF);
    irq_src = 16'h1234;
    step();
    mmio_read("raw_rd", 2'd2, 16'h1234);
    irq_src = 16'h0;
    step();

    if (exp_q.size() != 0) check_val("q_leftover", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mcpu_soc_intc.md
Name: mcpu_soc_intc

Overview:
- Interrupt controller for the MCPU SoC. Drives the core's int_pending/int_type inputs, which are currently tied to 0, and consumes the core's int_clear.
- Latches up to 16 peripheral interrupt sources, applies a software mask, priority-selects one source and holds it until the core acknowledges it.
- Software accesses it as an MMIO peripheral through the same word-addressed data_in/wren/data_out style as the other SoC peripherals.

Parameters:
- NSRC, 16, number of interrupt sources (1..16); source i is reported as int_type = i.
- EDGE_MASK, 16'hFFFF, per-source mode: 1 = rising-edge triggered, 0 = level triggered.

Ports:
- clkrst_core_clk  in  1  core clock; all logic is on its rising edge.
- clkrst_core_rst  in  1  synchronous, active-high reset.
- irq_src  in  NSRC  raw interrupt request lines, already synchronous to clkrst_core_clk.
- addr  in  2  MMIO word address: 0 PENDING, 1 MASK, 2 RAW, 3 FORCE.
- data_in  in  32  MMIO write data.
- wren  in  4  MMIO byte write enables; only [1:0] are used, since registers are 16 bits.
- re  in  1  MMIO read strobe.
- data_out  out  32  MMIO read data, valid the cycle after re.
- int_pending  out  1  an interrupt is presented to the core.
- int_type  out  4  index of the presented source.
- int_clear  in  1  core acknowledges the presented interrupt (single-cycle pulse).

Behaviour:
- Reset (synchronous, active-high) sets:
  - pending = 0, mask = 0, src_q = 0;
  - FSM = IDLE, int_pending = 0, int_type = 0, data_out = 0.
- src_q registers irq_src every cycle.
- Per-cycle event for source i:
  - edge mode: irq_src[i] & ~src_q[i];
  - level mode: irq_src[i].
- Pending update, evaluated at each edge:
  - pending_next = (pending & ~clr) | set.
  - set = events | FORCE write bits.
  - clr = PENDING write-1-to-clear bits | ack bit (one-hot at int_type when int_clear is high in PRESENT).
  - Set wins over clear on the same bit in the same cycle.
- Register writes: a byte lane is written only where wren[b] = 1. Lanes [3:2] are ignored. Bits at or above NSRC are ignored and read as 0.
- Register reads: data_out <= {16'h0, reg[addr]} when re is high, otherwise data_out holds its value.
  - RAW reads src_q.
  - FORCE reads 0.
- FSM state IDLE:
  - If (pending & mask) != 0: capture the lowest set index into int_type, set int_pending <= 1, go to PRESENT.
  - Arbitration uses register values from before the current edge's update.
- FSM state PRESENT:
  - int_type is frozen; there is no re-arbitration, even if a higher-priority source arrives.
  - On int_clear: go to IDLE, int_pending <= 0. The earliest re-presentation is int_pending high 2 cycles after the int_clear cycle.
  - If pending[int_type] is cleared by a software W1C, with no int_clear and no same-cycle set: withdraw, i.e. go to IDLE and int_pending <= 0.
  - Clearing a mask bit does not withdraw a presented interrupt.
- int_clear while in IDLE is ignored.
- Latency: an edge sampled at clock edge k sets pending at k; int_pending is high after edge k+1, if the source is unmasked and the FSM is IDLE.
- An edge-mode source re-firing while already pending is absorbed (one pending bit, no counting).
- A level-mode source re-sets pending the cycle after the ack if it is still asserted.
- Reset asserted mid-PRESENT: int_pending drops at that edge and all state is lost.

Test Plan:
- Reset, MASK=16'h0010, pulse irq_src[4] for 1 cycle -> PENDING reads 16'h0010; int_pending=1 with int_type=4 two edges after the pulse; int_clear pulse -> int_pending=0 next cycle and PENDING reads 0.
- MASK=16'hFFFF, pulse sources 9 and 3 together -> int_type=3; while presenting 3, pulse 1 -> int_type stays 3 until ack, then 1 is presented, then 9; PENDING reads 16'h0200 before the last ack.
- Hold edge-mode irq_src[2] high for 10 cycles with MASK bit 2 set -> exactly one presentation; after int_clear, no re-presentation while the line stays high.
- Level-mode source (EDGE_MASK bit 5 = 0) held high -> int_clear -> int_pending returns 2 cycles later with int_type=5; deassert the line and W1C 16'h0020 -> int_pending drops the next cycle and does not return.
- FORCE write 16'h8000 with MASK=0 -> PENDING=16'h8000 and int_pending stays 0; write MASK=16'h8000 -> int_type=15 presented; W1C PENDING 16'h8000 while presenting -> withdrawn (int_pending=0 next cycle).
- Same cycle: int_clear for source 7 and a new edge on irq_src[7] -> pending bit 7 stays 1 and source 7 is re-presented; assert clkrst_core_rst during PRESENT -> int_pending, PENDING and MASK are all 0 the next cycle.
